// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte-stream requesters, the arbiter and the shared uart_tx.
// The master modport is the arbiter's view; the slave modport is the surrounding environment's view.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   i_s_axis_tvalid;
    logic [8*N_REQ-1:0] i_s_axis_tdata;
    logic [N_REQ-1:0]   i_s_axis_tlast;
    logic [N_REQ-1:0]   o_s_axis_tready;
    logic               o_m_axis_tvalid;
    logic [7:0]         o_m_axis_tdata;
    logic               i_txd_busy;
    logic               i_txd_done;
    logic               o_grant_valid;
    logic [2:0]         o_grant_idx;
    logic               o_busy;

    modport master (
        input  i_s_axis_tvalid, i_s_axis_tdata, i_s_axis_tlast, i_txd_busy, i_txd_done,
        output o_s_axis_tready, o_m_axis_tvalid, o_m_axis_tdata, o_grant_valid, o_grant_idx, o_busy
    );

    modport slave (
        output i_s_axis_tvalid, i_s_axis_tdata, i_s_axis_tlast, i_txd_busy, i_txd_done,
        input  o_s_axis_tready, o_m_axis_tvalid, o_m_axis_tdata, o_grant_valid, o_grant_idx, o_busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-holding arbiter that shares one uart_tx between N_REQ AXIS byte streams,
// pacing one byte per UART frame from the UART's busy/done status.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    uart_tx_arbiter_if.master bus
);
    typedef enum logic [2:0] {SYNC, ARB, LOAD, ISSUE, WAIT_DONE, WAIT_IDLE} state_t;

    state_t           state;
    logic [2:0]       ptr;
    logic [2:0]       gidx;
    logic [15:0]      cnt;
    logic             cap_last;
    logic [N_REQ-1:0] tready;
    logic             m_tvalid;
    logic [7:0]       m_tdata;
    logic             grant_valid;
    logic             busy;

    logic             sel_found;
    logic [2:0]       sel_idx;
    logic             cur_valid;
    logic [7:0]       cur_data;
    logic             cur_last;
    logic             burst_hit;
    logic [2:0]       next_ptr;
    int               j;

    assign bus.o_s_axis_tready = tready;
    assign bus.o_m_axis_tvalid = m_tvalid;
    assign bus.o_m_axis_tdata  = m_tdata;
    assign bus.o_grant_valid   = grant_valid;
    assign bus.o_grant_idx     = gidx;
    assign bus.o_busy          = busy;

    // Scan upward from the pointer with wrap; also mux out the granted requester's stream.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cur_valid = 1'b0;
        cur_data  = '0;
        cur_last  = 1'b0;
        j         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!sel_found && bus.i_s_axis_tvalid[j]) begin
                sel_found = 1'b1;
                sel_idx   = 3'(j);
            end
            if (3'(i) == gidx) begin
                cur_valid = bus.i_s_axis_tvalid[i];
                cur_data  = bus.i_s_axis_tdata[8*i +: 8];
                cur_last  = bus.i_s_axis_tlast[i];
            end
        end
    end

    assign burst_hit = (MAX_BURST != 0) && (cnt == 16'(MAX_BURST));
    assign next_ptr  = (gidx == 3'(N_REQ - 1)) ? 3'd0 : gidx + 3'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= SYNC;
            ptr         <= '0;
            gidx        <= '0;
            cnt         <= '0;
            cap_last    <= 1'b0;
            tready      <= '0;
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            grant_valid <= 1'b0;
            busy        <= 1'b1;
        end else begin
            case (state)
                // A frame may still be in flight from before reset; wait for a fully idle UART.
                SYNC: begin
                    if (!bus.i_txd_busy && !bus.i_txd_done) begin
                        state <= ARB;
                        busy  <= 1'b0;
                    end
                end
                ARB: begin
                    if (sel_found) begin
                        grant_valid <= 1'b1;
                        gidx        <= sel_idx;
                        busy        <= 1'b1;
                        state       <= LOAD;
                        for (int i = 0; i < N_REQ; i++) tready[i] <= (3'(i) == sel_idx);
                    end
                end
                LOAD: begin
                    if (cur_valid) begin
                        m_tdata  <= cur_data;
                        cap_last <= cur_last;
                        cnt      <= cnt + 16'd1;
                        tready   <= '0;
                        m_tvalid <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.i_txd_busy) begin
                        m_tvalid <= 1'b0;
                        state    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.i_txd_done) state <= WAIT_IDLE;
                end
                // The fall of done is the only guarantee that the UART is idle again.
                WAIT_IDLE: begin
                    if (!bus.i_txd_done) begin
                        if (cap_last || burst_hit) begin
                            ptr         <= next_ptr;
                            cnt         <= '0;
                            grant_valid <= 1'b0;
                            busy        <= 1'b0;
                            state       <= ARB;
                        end else begin
                            state <= LOAD;
                            for (int i = 0; i < N_REQ; i++) tready[i] <= (3'(i) == gidx);
                        end
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end
endmodule
